// File: rtl/multpool_wdata_demux_if.sv
// rtl/multpool_wdata_demux_if.sv - write-stream and bank-side bundle for the multpool write-data demux
interface multpool_wdata_demux_if #(
  parameter int NBITS     = 256,
  parameter int NUM_WDATA = 1024,
  parameter int AW        = $clog2(NUM_WDATA)
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [AW-1:0]        wr_addr;
  logic [3*NBITS-1:0]   wr_data;
  logic                 mem_stall;
  logic [NUM_WDATA-1:0] bank_we;
  logic [3*NBITS-1:0]   bank_wdata;
  logic                 wr_err;
  logic                 idle;

  modport master (
    output wr_valid, wr_addr, wr_data, mem_stall,
    input  wr_ready, bank_we, bank_wdata, wr_err, idle
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, mem_stall,
    output wr_ready, bank_we, bank_wdata, wr_err, idle
  );
endinterface

// File: rtl/multpool_wdata_demux.sv
// rtl/multpool_wdata_demux.sv - two-stage write fan-out: group decode, then per-group one-hot expand
module multpool_wdata_demux #(
  parameter int NBITS     = 256,
  parameter int NUM_WDATA = 1024,
  parameter int AW        = $clog2(NUM_WDATA),
  parameter int NGRP      = 4
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  multpool_wdata_demux_if.slave bus
);
  localparam int GSZ = NUM_WDATA / NGRP;
  localparam int GW  = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int DW  = 3 * NBITS;

  logic                 s1_vld, s1_oor, s2_vld;
  logic [GW-1:0]        s1_grp;
  logic [AW-1:0]        s1_off;
  logic [DW-1:0]        s1_data;
  logic                 adv, accept, oor;
  logic [GW-1:0]        grp;
  logic [AW-1:0]        off;
  logic [NUM_WDATA-1:0] we_nxt;

  assign adv          = !bus.mem_stall;
  assign bus.wr_ready = !s1_vld || adv;
  assign accept       = bus.wr_valid && bus.wr_ready;
  assign bus.idle     = !s1_vld && !s2_vld;

  // Range compare rather than a divide; the last group absorbs the remainder.
  always_comb begin
    grp = '0;
    for (int g = 1; g < NGRP; g++) begin
      if (int'(bus.wr_addr) >= g * GSZ) grp = GW'(g);
    end
    off = AW'(int'(bus.wr_addr) - int'(grp) * GSZ);
    oor = int'(bus.wr_addr) >= NUM_WDATA;
  end

  // Each group expands only its own slice, keeping offset fan-out to one group.
  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    localparam int BASE = g * GSZ;
    localparam int SIZE = (g == NGRP - 1) ? NUM_WDATA - BASE : GSZ;
    logic hit;
    assign hit = s1_vld && !s1_oor && (s1_grp == GW'(g));
    for (genvar j = 0; j < SIZE; j++) begin : g_bit
      assign we_nxt[BASE+j] = hit && (s1_off == AW'(j));
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      s1_vld         <= 1'b0;
      s1_grp         <= '0;
      s1_off         <= '0;
      s1_oor         <= 1'b0;
      s1_data        <= '0;
      s2_vld         <= 1'b0;
      bus.bank_we    <= '0;
      bus.bank_wdata <= '0;
      bus.wr_err     <= 1'b0;
    end else begin
      // An empty S1 still takes a request during a stall so an accepted write is never lost.
      if (accept || adv) s1_vld <= accept;
      if (accept) begin
        s1_grp  <= grp;
        s1_off  <= off;
        s1_oor  <= oor;
        s1_data <= bus.wr_data;
      end
      if (adv) begin
        s2_vld      <= s1_vld;
        bus.bank_we <= we_nxt;
        bus.wr_err  <= s1_vld && s1_oor;
        if (s1_vld) bus.bank_wdata <= s1_data;
      end
    end
  end
endmodule

// File: tb/tb_multpool_wdata_demux.sv
// tb/tb_multpool_wdata_demux.sv - vector table, reset and random-stream scoreboard for multpool_wdata_demux
module tb_multpool_wdata_demux;
  localparam int NB = 8, NW = 1000, AW = 10, DW = 24;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  multpool_wdata_demux_if #(.NBITS(NB), .NUM_WDATA(NW), .AW(AW)) bus ();
  multpool_wdata_demux #(.NBITS(NB), .NUM_WDATA(NW), .AW(AW), .NGRP(4)) dut (
    .hclk(hclk), .hresetn(hresetn), .bus(bus)
  );

  typedef struct {
    logic v; int a; logic [DW-1:0] d; logic st;
    logic rdy; int we; logic [DW-1:0] wd; logic err; logic idl;
  } vec_t;
  vec_t vt[$];

  int n_chk = 0, n_fail = 0;

  function automatic int first_idx(input logic [NW-1:0] v);
    for (int i = 0; i < NW; i++) if (v[i] === 1'b1) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_we(input string name, input int idx);
    logic [NW-1:0] e;
    e = '0;
    if (idx >= 0) e[idx] = 1'b1;
    n_chk++;
    if (bus.bank_we !== e) begin
      n_fail++;
      $display("FAIL %s: bank_we first=%0d ones=%0d expected index %0d",
               name, first_idx(bus.bank_we), $countones(bus.bank_we), idx);
    end
  endtask

  function automatic void add(logic v, int a, logic [DW-1:0] d, logic st,
                              logic rdy, int we, logic [DW-1:0] wd, logic err, logic idl);
    vec_t t;
    t.v = v; t.a = a; t.d = d; t.st = st;
    t.rdy = rdy; t.we = we; t.wd = wd; t.err = err; t.idl = idl;
    vt.push_back(t);
  endfunction

  int            exp_a[$];
  logic [DW-1:0] exp_d[$];
  int            wcnt, cyc, addr, ea;
  logic          pend;
  logic [DW-1:0] ed;

  task automatic commit_check();
    check("popcount", 32'($countones(bus.bank_we) <= 1), 32'd1);
    if (!bus.mem_stall && (bus.bank_we != '0 || bus.wr_err)) begin
      if (exp_a.size() == 0) begin
        check("spurious_commit", 32'(first_idx(bus.bank_we)), 32'hFFFF_FFFF);
      end else begin
        ea = exp_a.pop_front();
        ed = exp_d.pop_front();
        if (ea >= NW) begin
          check("rnd_err", {31'd0, bus.wr_err}, 32'd1);
          check("rnd_err_we", 32'(first_idx(bus.bank_we)), 32'hFFFF_FFFF);
        end else begin
          check("rnd_idx", 32'(first_idx(bus.bank_we)), 32'(ea));
          check("rnd_data", 32'(bus.bank_wdata), 32'(ed));
        end
      end
    end
  endtask

  initial begin
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.mem_stall = 1'b0;
    repeat (3) @(negedge hclk);
    #1;
    check_we("rst_we", -1);
    check("rst_wdata", 32'(bus.bank_wdata), 32'd0);
    check("rst_err", {31'd0, bus.wr_err}, 32'd0);
    check("rst_idle", {31'd0, bus.idle}, 32'd1);
    @(negedge hclk);
    hresetn = 1'b1;
    #1 check("rst_ready", {31'd0, bus.wr_ready}, 32'd1);

    // Single write, then group boundaries (GSZ=250), then out-of-range, then stall.
    add(1, 0, 24'hA5A5A5, 0, 1, -1, 24'h0, 0, 0);
    add(0, 0, 24'h0,      0, 1,  0, 24'hA5A5A5, 0, 0);
    add(0, 0, 24'h0,      0, 1, -1, 24'hA5A5A5, 0, 1);
    add(1, 249, 24'hB000F9, 0, 1, -1,  24'hA5A5A5, 0, 0);
    add(1, 250, 24'hB000FA, 0, 1, 249, 24'hB000F9, 0, 0);
    add(1, 499, 24'hB001F3, 0, 1, 250, 24'hB000FA, 0, 0);
    add(1, 500, 24'hB001F4, 0, 1, 499, 24'hB001F3, 0, 0);
    add(1, 749, 24'hB002ED, 0, 1, 500, 24'hB001F4, 0, 0);
    add(1, 750, 24'hB002EE, 0, 1, 749, 24'hB002ED, 0, 0);
    add(1, 999, 24'hB003E7, 0, 1, 750, 24'hB002EE, 0, 0);
    add(0, 0, 24'h0,        0, 1, 999, 24'hB003E7, 0, 0);
    add(0, 0, 24'h0,        0, 1, -1,  24'hB003E7, 0, 1);
    add(1, 1005, 24'hC0FFEE, 0, 1, -1, 24'hB003E7, 0, 0);
    add(1, 3,    24'h123456, 0, 1, -1, 24'hC0FFEE, 1, 0);
    add(0, 0, 24'h0,         0, 1,  3, 24'h123456, 0, 0);
    add(0, 0, 24'h0,         0, 1, -1, 24'h123456, 0, 1);
    add(1, 10, 24'hD0000A, 0, 1, -1, 24'h123456, 0, 0);
    add(1, 11, 24'hD0000B, 0, 1, 10, 24'hD0000A, 0, 0);
    add(1, 12, 24'hD0000C, 1, 0, 10, 24'hD0000A, 0, 0);
    add(1, 12, 24'hD0000C, 1, 0, 10, 24'hD0000A, 0, 0);
    add(1, 12, 24'hD0000C, 1, 0, 10, 24'hD0000A, 0, 0);
    add(1, 12, 24'hD0000C, 0, 1, 11, 24'hD0000B, 0, 0);
    add(0, 0, 24'h0,       0, 1, 12, 24'hD0000C, 0, 0);
    add(0, 0, 24'h0,       0, 1, -1, 24'hD0000C, 0, 1);

    foreach (vt[i]) begin
      @(negedge hclk);
      bus.wr_valid = vt[i].v; bus.wr_addr = AW'(vt[i].a);
      bus.wr_data = vt[i].d; bus.mem_stall = vt[i].st;
      #1 check($sformatf("v%0d_ready", i), {31'd0, bus.wr_ready}, {31'd0, vt[i].rdy});
      @(posedge hclk);
      #1;
      check_we($sformatf("v%0d_we", i), vt[i].we);
      check($sformatf("v%0d_wdata", i), 32'(bus.bank_wdata), 32'(vt[i].wd));
      check($sformatf("v%0d_err", i), {31'd0, bus.wr_err}, {31'd0, vt[i].err});
      check($sformatf("v%0d_idle", i), {31'd0, bus.idle}, {31'd0, vt[i].idl});
    end

    // Reset while one write sits in S2 and another in S1.
    @(negedge hclk);
    bus.wr_valid = 1'b1; bus.wr_addr = AW'(20); bus.wr_data = 24'hF00014; bus.mem_stall = 1'b0;
    @(negedge hclk);
    bus.wr_addr = AW'(21); bus.wr_data = 24'hF00015;
    @(negedge hclk);
    bus.wr_valid = 1'b0;
    #1 check_we("mid_pre_we", 20);
    hresetn = 1'b0;
    #1;
    check_we("mid_rst_we", -1);
    check("mid_rst_idle", {31'd0, bus.idle}, 32'd1);
    check("mid_rst_err", {31'd0, bus.wr_err}, 32'd0);
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge hclk);
      #1 check_we($sformatf("mid_post%0d_we", k), -1);
    end

    // Random stream with 30% stall; a refused request is held until taken.
    wcnt = 0; cyc = 0; pend = 1'b0;
    while (wcnt < 10000 && cyc < 40000) begin
      @(negedge hclk);
      bus.mem_stall = ($urandom_range(99) < 30);
      if (!pend) begin
        bus.wr_valid = ($urandom_range(99) < 80);
        addr = ($urandom_range(99) < 5) ? int'($urandom_range(1023, 1000)) : int'($urandom_range(NW - 1));
        bus.wr_addr = AW'(addr);
        bus.wr_data = DW'($urandom);
      end
      #1;
      pend = bus.wr_valid && !bus.wr_ready;
      if (bus.wr_valid && bus.wr_ready) begin
        exp_a.push_back(int'(bus.wr_addr));
        exp_d.push_back(bus.wr_data);
        wcnt++;
      end
      commit_check();
      cyc++;
    end
    check("rnd_write_count", 32'(wcnt), 32'd10000);
    @(negedge hclk);
    bus.wr_valid = 1'b0; bus.mem_stall = 1'b0;
    for (int k = 0; k < 20 && exp_a.size() > 0; k++) begin
      #1 commit_check();
      @(negedge hclk);
    end
    check("rnd_drained", 32'(exp_a.size()), 32'd0);
    check("rnd_idle", {31'd0, bus.idle}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
